pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipe (IF, ID, EX, MEM, WB); ID reads the regfile and resolves branches.
//  Keeps a shadow copy of in-flight destination registers (EX/MEM/WB) and interlocks ID on RAW hazards (no forwarding).
//  Squashes the IF/ID register on a taken branch and freezes the whole pipe while data memory is busy.
//  Counts stall cycles for performance debug.
// PARAMETERS
//  PERF_W   32  width of stall-cycle counter (saturating)
//  RF_AW    5   register address width
// PORTS
//  clk            in   1       clock, all state on posedge
//  rst            in   1       asynchronous, active-high reset
//  ds_valid       in   1       ID holds a valid instruction
//  ds_rs1         in   RF_AW   ID source 1 address
//  ds_rs2         in   RF_AW   ID source 2 address
//  ds_rs1_used    in   1       instruction reads rs1
//  ds_rs2_used    in   1       instruction reads rs2
//  ds_rd          in   RF_AW   ID destination
//  ds_we          in   1       ID instruction writes rd
//  ds_branch_taken in  1       ID branch/jump resolved taken (ds_branch_control)
//  ms_mem_req     in   1       MEM stage issuing a load/store this cycle
//  dmem_ready     in   1       data memory completes the request this cycle
//  pc_stall       out  1       hold PC
//  fs_ds_stall    out  1       hold IF/ID register
//  fs_ds_flush    out  1       load NOP into IF/ID register
//  ds_es_bubble   out  1       load NOP into ID/EX register
//  pipe_freeze    out  1       hold ID/EX, EX/MEM, MEM/WB registers
//  stall_cnt      out  PERF_W  cycles with pc_stall=1, saturates at all-ones
// BEHAVIOUR
//  Reset: state=RUN; shadow slots ex/mem/wb we=0, rd=0; stall_cnt=0; all control outputs 0 (combinational from reset state).
//  Control outputs are combinational from inputs + state (zero latency); all state updates on posedge clk.
//  haz = ds_valid & any slot s in {ex,mem,wb}: s.we & s.rd!=0 & ((ds_rs1_used & ds_rs1==s.rd) | (ds_rs2_used & ds_rs2==s.rd)).
//  WB slot counts: regfile write in WB is not visible to the ID read in the same cycle.
//  mwait = ms_mem_req & ~dmem_ready (in RUN) or ~dmem_ready (in MEM_WAIT).
//  FSM RUN:      mwait -> MEM_WAIT; else stay.
//  FSM MEM_WAIT: dmem_ready -> RUN; else stay. ms_mem_req is held by the frozen MEM stage.
//  Priority per cycle: mwait > haz > branch.
//   mwait:  pc_stall=fs_ds_stall=pipe_freeze=1, bubble=0, flush=0; shadow slots hold; ds_branch_taken ignored.
//   haz:    pc_stall=fs_ds_stall=1, ds_es_bubble=1; shadow: ex<=0, mem<=ex, wb<=mem; ds_branch_taken ignored (operands stale).
//   taken:  fs_ds_flush=1 (one bubble), no stall; shadow ex<={ds_we&ds_valid, ds_rd}, mem<=ex, wb<=mem.
//   none:   all outputs 0; shadow advances as in taken.
//  ds_valid=0: no hazard and no shadow entry (ex<=0).
//  rd==0 never creates a hazard and never enters the shadow (we forced 0).
//  stall_cnt += 1 on every cycle with pc_stall=1 until 2^PERF_W-1, then holds.
//  Mid-operation rst: asynchronous return to the reset state, including out of MEM_WAIT; no pending flush survives.
//  dmem_ready with ms_mem_req=0 in RUN: no effect.
// STRUCTURE
//  pipeline.vh: FSM state encodings (ST_RUN, ST_MEM_WAIT), RF_AW, NOP constant for bubble/flush users.
//  Sub-module hazard_scoreboard: 3-slot rd/we shadow shift register with hold/bubble inputs and a match output.
//  Top: FSM, priority mux, stall counter.
// TESTING
//  1. rst=1, then rst=0 idle -> all outputs 0, stall_cnt=0, state RUN.
//  2. ID: addi x5 (we, rd=5), next ID: add reads rs1=x5 -> pc_stall=1 for 3 cycles, ds_es_bubble=1 for 3 cycles, then clear; stall_cnt=3.
//  3. ID writes rd=x0, next instr reads x0 -> no stall.
//  4. ds_branch_taken=1 with no hazard -> fs_ds_flush=1 for exactly 1 cycle, pc_stall=0.
//  5. ms_mem_req=1, dmem_ready=0 for 4 cycles, then 1 -> pipe_freeze=1 for 4 cycles, back to RUN on cycle 5; concurrent branch_taken gives no flush.
//  6. rst asserted during MEM_WAIT -> outputs 0 immediately, state RUN, shadow cleared; a following read of the previous rd does not stall.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and default sizes for the pipeline stall/flush sequencer.
// Imported by the top and by the in-flight destination scoreboard.
package pipe_hazard_ctrl_pkg;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    localparam int RF_AW_DEF  = 5;
    localparam int PERF_W_DEF = 32;
    localparam int N_SLOTS    = 3;

endpackage

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// Purpose: shadow of EX/MEM/WB destination registers; flags RAW hazards for the ID instruction.
// Latency: o_match is combinational; slots shift on posedge. Backpressure: i_hold freezes all slots.
module pipe_hazard_ctrl_scoreboard
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int RF_AW = RF_AW_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_hold,
    input  logic             i_bubble,
    input  logic             i_ds_valid,
    input  logic             i_ds_we,
    input  logic [RF_AW-1:0] i_ds_rd,
    input  logic [RF_AW-1:0] i_ds_rs1,
    input  logic [RF_AW-1:0] i_ds_rs2,
    input  logic             i_ds_rs1_used,
    input  logic             i_ds_rs2_used,
    output logic             o_match
);

    // Slot 0 = EX, 1 = MEM, 2 = WB.
    logic [N_SLOTS-1:0] r_we;
    logic [RF_AW-1:0]   r_rd [N_SLOTS];

    logic             w_hit;
    logic             w_new_we;
    logic [RF_AW-1:0] w_new_rd;

    always_comb begin
        w_hit = 1'b0;
        for (int s = 0; s < N_SLOTS; s++) begin
            if (r_we[s] && (r_rd[s] != '0)) begin
                if ((i_ds_rs1_used && (i_ds_rs1 == r_rd[s])) ||
                    (i_ds_rs2_used && (i_ds_rs2 == r_rd[s]))) begin
                    w_hit = 1'b1;
                end
            end
        end
        o_match = i_ds_valid & w_hit;
    end

    // x0 never enters the shadow, so it can never cause an interlock later.
    always_comb begin
        w_new_we = ~i_bubble & i_ds_valid & i_ds_we & (i_ds_rd != '0);
        w_new_rd = w_new_we ? i_ds_rd : '0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_we <= '0;
            for (int s = 0; s < N_SLOTS; s++) begin
                r_rd[s] <= '0;
            end
        end else if (!i_hold) begin
            r_we[0] <= w_new_we;
            r_rd[0] <= w_new_rd;
            for (int s = 1; s < N_SLOTS; s++) begin
                r_we[s] <= r_we[s-1];
                r_rd[s] <= r_rd[s-1];
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Purpose: stall/flush/freeze sequencer for a 5-stage pipe with RAW interlock and stall counter.
// Latency: control outputs are combinational (zero cycles). Backpressure: dmem wait freezes the pipe.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int PERF_W = PERF_W_DEF,
    parameter int RF_AW  = RF_AW_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ds_valid,
    input  logic [RF_AW-1:0]  i_ds_rs1,
    input  logic [RF_AW-1:0]  i_ds_rs2,
    input  logic              i_ds_rs1_used,
    input  logic              i_ds_rs2_used,
    input  logic [RF_AW-1:0]  i_ds_rd,
    input  logic              i_ds_we,
    input  logic              i_ds_branch_taken,
    input  logic              i_ms_mem_req,
    input  logic              i_dmem_ready,
    output logic              o_pc_stall,
    output logic              o_fs_ds_stall,
    output logic              o_fs_ds_flush,
    output logic              o_ds_es_bubble,
    output logic              o_pipe_freeze,
    output logic [PERF_W-1:0] o_stall_cnt
);

    state_t            r_state;
    logic [PERF_W-1:0] r_stall_cnt;

    logic w_mwait;
    logic w_haz;
    logic w_run;

    // While reset is held every control output reads 0 regardless of inputs.
    assign w_run = ~i_rst;

    always_comb begin
        if (r_state == ST_RUN) begin
            w_mwait = i_ms_mem_req & ~i_dmem_ready;
        end else begin
            w_mwait = ~i_dmem_ready;
        end
    end

    pipe_hazard_ctrl_scoreboard #(
        .RF_AW (RF_AW)
    ) u_scoreboard (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_hold        (w_mwait),
        .i_bubble      (w_haz),
        .i_ds_valid    (i_ds_valid),
        .i_ds_we       (i_ds_we),
        .i_ds_rd       (i_ds_rd),
        .i_ds_rs1      (i_ds_rs1),
        .i_ds_rs2      (i_ds_rs2),
        .i_ds_rs1_used (i_ds_rs1_used),
        .i_ds_rs2_used (i_ds_rs2_used),
        .o_match       (w_haz)
    );

    // Priority: memory wait, then RAW interlock, then taken branch.
    always_comb begin
        o_pipe_freeze  = w_run & w_mwait;
        o_pc_stall     = w_run & (w_mwait | w_haz);
        o_fs_ds_stall  = w_run & (w_mwait | w_haz);
        o_ds_es_bubble = w_run & ~w_mwait & w_haz;
        o_fs_ds_flush  = w_run & ~w_mwait & ~w_haz & i_ds_branch_taken;
        o_stall_cnt    = r_stall_cnt;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_RUN;
        end else begin
            case (r_state)
                ST_RUN:      if (w_mwait)      r_state <= ST_MEM_WAIT;
                ST_MEM_WAIT: if (i_dmem_ready) r_state <= ST_RUN;
                default:                       r_state <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stall_cnt <= '0;
        end else if (o_pc_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench: stimulus pushes hand-computed expectations, a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       ds_valid;
    logic [4:0] ds_rs1, ds_rs2, ds_rd;
    logic       ds_rs1_used, ds_rs2_used, ds_we, ds_br;
    logic       ms_mem_req, dmem_ready;

    logic        pc_stall, fs_ds_stall, fs_ds_flush, ds_es_bubble, pipe_freeze;
    logic [31:0] stall_cnt;
    logic        s_pc_stall, s_fs_ds_stall, s_fs_ds_flush, s_ds_es_bubble, s_pipe_freeze;
    logic [1:0]  s_stall_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.PERF_W(32), .RF_AW(5)) dut (
        .i_clk(clk), .i_rst(rst), .i_ds_valid(ds_valid),
        .i_ds_rs1(ds_rs1), .i_ds_rs2(ds_rs2),
        .i_ds_rs1_used(ds_rs1_used), .i_ds_rs2_used(ds_rs2_used),
        .i_ds_rd(ds_rd), .i_ds_we(ds_we), .i_ds_branch_taken(ds_br),
        .i_ms_mem_req(ms_mem_req), .i_dmem_ready(dmem_ready),
        .o_pc_stall(pc_stall), .o_fs_ds_stall(fs_ds_stall), .o_fs_ds_flush(fs_ds_flush),
        .o_ds_es_bubble(ds_es_bubble), .o_pipe_freeze(pipe_freeze), .o_stall_cnt(stall_cnt)
    );

    // Narrow counter instance exposes the saturation boundary.
    pipe_hazard_ctrl #(.PERF_W(2), .RF_AW(5)) dut_sat (
        .i_clk(clk), .i_rst(rst), .i_ds_valid(ds_valid),
        .i_ds_rs1(ds_rs1), .i_ds_rs2(ds_rs2),
        .i_ds_rs1_used(ds_rs1_used), .i_ds_rs2_used(ds_rs2_used),
        .i_ds_rd(ds_rd), .i_ds_we(ds_we), .i_ds_branch_taken(ds_br),
        .i_ms_mem_req(ms_mem_req), .i_dmem_ready(dmem_ready),
        .o_pc_stall(s_pc_stall), .o_fs_ds_stall(s_fs_ds_stall), .o_fs_ds_flush(s_fs_ds_flush),
        .o_ds_es_bubble(s_ds_es_bubble), .o_pipe_freeze(s_pipe_freeze), .o_stall_cnt(s_stall_cnt)
    );

    typedef struct {
        string       name;
        logic        stall;
        logic        flush;
        logic        bubble;
        logic        freeze;
        logic [31:0] cnt;
        logic [1:0]  cnt_sat;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Monitor: outputs are combinational, so each cycle presents one result at negedge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [9:0] act, req;
            e = exp_q.pop_front();
            act = {pc_stall, fs_ds_stall, fs_ds_flush, ds_es_bubble, pipe_freeze,
                   s_pc_stall, s_fs_ds_flush, s_ds_es_bubble, s_pipe_freeze, 1'b0};
            req = {e.stall, e.stall, e.flush, e.bubble, e.freeze,
                   e.stall, e.flush, e.bubble, e.freeze, 1'b0};
            n_vec++;
            if (act !== req || stall_cnt !== e.cnt || s_stall_cnt !== e.cnt_sat) begin
                n_miss++;
                $display("FAIL %s: got ctl=%b cnt=%0d sat=%0d, want ctl=%b cnt=%0d sat=%0d",
                         e.name, act, stall_cnt, s_stall_cnt, req, e.cnt, e.cnt_sat);
            end
        end
    end

    // Drive one cycle of inputs and push the hand-computed response for that cycle.
    task automatic vec(input string name, input logic r, input logic v,
                       input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic we, input logic br,
                       input logic mreq, input logic drdy,
                       input logic e_stall, input logic e_flush, input logic e_bub, input logic e_frz,
                       input int e_cnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; ds_valid = v; ds_rs1 = rs1; ds_rs1_used = u1; ds_rs2 = rs2; ds_rs2_used = u2;
        ds_rd = rd; ds_we = we; ds_br = br; ms_mem_req = mreq; dmem_ready = drdy;
        e.name = name; e.stall = e_stall; e.flush = e_flush; e.bubble = e_bub; e.freeze = e_frz;
        e.cnt = e_cnt;
        e.cnt_sat = (e_cnt > 3) ? 2'd3 : e_cnt[1:0];
        exp_q.push_back(e);
    endtask

    task automatic idle(input string name, input int cnt);
        vec(name, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, cnt);
    endtask

    initial begin
        rst = 1'b1; ds_valid = 0; ds_rs1 = 0; ds_rs2 = 0; ds_rs1_used = 0; ds_rs2_used = 0;
        ds_rd = 0; ds_we = 0; ds_br = 0; ms_mem_req = 0; dmem_ready = 0;

        // Reset holds all outputs low even with a pending memory wait on the inputs.
        vec("rst_mask", 1, 1, 0, 0, 0, 0, 3, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        idle("reset_idle0", 0);
        idle("reset_idle1", 0);

        // RAW via EX, MEM, WB slots: three stalls then release.
        vec("addi_x5",   0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        vec("raw_ex",    0, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 1, 0, 1, 0, 0);
        vec("raw_mem",   0, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 1, 0, 1, 0, 1);
        vec("raw_wb",    0, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 1, 0, 1, 0, 2);
        vec("raw_clear", 0, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0, 3);
        idle("drain0", 3);

        // x0 destination never interlocks; unused rs2 never interlocks.
        vec("wr_x0",      0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 3);
        vec("rd_x0",      0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
        vec("wr_x7",      0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0, 3);
        vec("rs2_unused", 0, 1, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
        vec("rs2_mem",    0, 1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 3);
        vec("rs2_wb",     0, 1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 4);
        vec("rs2_clear",  0, 1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5);

        // Taken branch: single-cycle flush, no stall.
        vec("br_taken", 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 5);
        idle("br_after", 5);

        // Memory wait: four frozen cycles, a branch during freeze is ignored, release on ready.
        vec("mw0",     0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 5);
        vec("mw1",     0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 6);
        vec("mw2_br",  0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 1, 7);
        vec("mw3",     0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 8);
        vec("mw_done", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 9);
        vec("rdy_noreq", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 9);
        vec("req_rdy",   0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 9);

        // Shadow holds across a freeze: producer stays in EX until the memory completes.
        vec("wr_x9",      0, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0, 0, 9);
        vec("frz_raw",    0, 1, 9, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 9);
        vec("held_ex",    0, 1, 9, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 10);
        vec("held_mem",   0, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 11);
        vec("held_wb",    0, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 12);
        vec("held_clear", 0, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 13);

        // Reset out of MEM_WAIT clears state, counter and shadow.
        vec("wr_x12",   0, 1, 0, 0, 0, 0, 12, 1, 0, 0, 0, 0, 0, 0, 0, 13);
        vec("mw_enter", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 13);
        vec("mw_rst",   1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        vec("post_rst", 0, 1, 12, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle("post_rst_idle", 0);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_miss++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
